// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants, fetch FSM states and register-field helpers
// shared by fetch, decode and the hazard unit.  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam int REG_W   = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [REG_W-1:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: REG_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry PC+instruction holding register (load/clear/full).
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            full,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  // clear wins so a redirect always empties the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
    end else if (clear) begin
      full      <= 1'b0;
    end else if (load) begin
      full      <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem request sequencer and
// IF/ID pipeline register with skid buffer for responses landing in a stall. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [4:0]      if_id_rs1,
  output logic [4:0]      if_id_rs2
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] inflight_pc, inflight_nxt;
  logic            kill, kill_nxt;
  logic            valid_nxt;
  logic [XLEN-1:0] ifpc_nxt;
  logic [31:0]     instr_nxt;
  logic            skid_load, skid_clear, skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .in_pc     (inflight_pc),
    .in_instr  (imem_rdata),
    .full      (skid_full),
    .out_pc    (skid_pc),
    .out_instr (skid_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      kill        <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inflight_pc <= inflight_nxt;
      kill        <= kill_nxt;
      if_id_valid <= valid_nxt;
      if_id_pc    <= ifpc_nxt;
      if_id_instr <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    inflight_nxt = inflight_pc;
    kill_nxt     = kill;
    valid_nxt    = if_id_valid;
    ifpc_nxt     = if_id_pc;
    instr_nxt    = if_id_instr;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (!stall) begin
      valid_nxt = 1'b0;
      instr_nxt = NOP_INSTR;
    end

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ready) begin
          inflight_nxt = pc;
          pc_nxt       = pc + XLEN'(4);
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            kill_nxt  = 1'b0;
            state_nxt = REQ;
          end else if (!stall) begin
            valid_nxt = 1'b1;
            ifpc_nxt  = inflight_pc;
            instr_nxt = imem_rdata;
            state_nxt = REQ;
          end else begin
            skid_load = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall && skid_full) begin
          valid_nxt  = 1'b1;
          ifpc_nxt   = skid_pc;
          instr_nxt  = skid_instr;
          skid_clear = 1'b1;
          state_nxt  = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // a response still owed by memory must be swallowed when it returns
    if (redirect) begin
      pc_nxt     = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
      valid_nxt  = 1'b0;
      instr_nxt  = NOP_INSTR;
      skid_load  = 1'b0;
      skid_clear = 1'b1;
      if ((state == WAIT && !imem_rvalid) || (state == REQ && imem_ready)) begin
        kill_nxt  = 1'b1;
        state_nxt = WAIT;
      end else begin
        kill_nxt  = 1'b0;
        state_nxt = REQ;
      end
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign if_id_rs1 = if_id_valid ? rs1_of(if_id_instr) : 5'd0;
  assign if_id_rs2 = if_id_valid ? rs2_of(if_id_instr) : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then randomized traffic against a
// transaction-level model of fetch order and delivered instructions. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk, rst_n, stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, if_id_pc, if_id_instr;
  logic        imem_req, if_id_valid;
  logic [4:0]  if_id_rs1, if_id_rs2;

  int          n_cmp = 0, n_err = 0, n_deliv = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_a = '0;
  logic [31:0] exp_fetch = RPC;
  logic [31:0] pend[$];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_0093;
      32'h4:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc",    if_id_pc,             32'd0);
    chk("rst_instr", if_id_instr,          NOP);
    chk("rst_rs1",   {27'd0, if_id_rs1},   32'd0);
    chk("rst_rs2",   {27'd0, if_id_rs2},   32'd0);
  endtask

  // One clock cycle: apply inputs, check the accepted address, then check IF/ID.
  task automatic step(input logic st, input logic rd, input logic [31:0] rp,
                      input logic rdy, input int lat);
    logic        acc, sv_valid;
    logic [31:0] obs_addr, sv_pc, sv_instr, e_pc, e_instr;
    logic [4:0]  sv_rs1, sv_rs2;
    stall = st; redirect = rd; redirect_pc = rp; imem_ready = rdy;
    #1;
    acc      = imem_req && rdy;
    obs_addr = imem_addr;
    if (acc) chk("req_addr", obs_addr, exp_fetch);
    sv_valid = if_id_valid; sv_pc = if_id_pc; sv_instr = if_id_instr;
    sv_rs1 = if_id_rs1; sv_rs2 = if_id_rs2;
    @(posedge clk); #1;

    if (acc) begin mem_cnt = lat; mem_a = obs_addr; end
    imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = instr_at(mem_a); end
    end

    if (!rst_n) begin
      pend.delete();
      exp_fetch = RPC;
      chk("rst_hold_valid", {31'd0, if_id_valid}, 32'd0);
    end else if (rd) begin
      exp_fetch = rp & 32'hFFFF_FFFC;
      pend.delete();
      chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
      chk("redir_instr", if_id_instr, NOP);
    end else begin
      if (acc) begin pend.push_back(exp_fetch); exp_fetch = exp_fetch + 32'd4; end
      if (st) begin
        chk("hold_valid", {31'd0, if_id_valid}, {31'd0, sv_valid});
        chk("hold_pc",    if_id_pc,    sv_pc);
        chk("hold_instr", if_id_instr, sv_instr);
        chk("hold_rs",    {22'd0, if_id_rs1, if_id_rs2}, {22'd0, sv_rs1, sv_rs2});
      end else if (if_id_valid) begin
        if (pend.size() == 0) begin
          chk("spurious_delivery", {31'd0, if_id_valid}, 32'd0);
        end else begin
          e_pc    = pend.pop_front();
          e_instr = instr_at(e_pc);
          n_deliv++;
          chk("deliv_pc",    if_id_pc,    e_pc);
          chk("deliv_instr", if_id_instr, e_instr);
          chk("deliv_rs1",   {27'd0, if_id_rs1}, {27'd0, e_instr[19:15]});
          chk("deliv_rs2",   {27'd0, if_id_rs2}, {27'd0, e_instr[24:20]});
        end
      end else begin
        chk("bubble_instr", if_id_instr, NOP);
        chk("bubble_rs",    {22'd0, if_id_rs1, if_id_rs2}, 32'd0);
      end
    end
    chk("pend_depth", {31'd0, pend.size() <= 1}, 32'd1);
  endtask

  initial begin
    clk = 0; rst_n = 0; stall = 0; redirect = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1; #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // first fetch: request at cycle 1, 1-cycle memory
    step(0, 0, 0, 1, 1);
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("t1_valid", {31'd0, if_id_valid}, 32'd1);
    chk("t1_pc",    if_id_pc, 32'h0);
    chk("t1_rs",    {22'd0, if_id_rs1, if_id_rs2}, {22'd0, 5'd0, 5'd10});

    // stall over the response: skid holds it, no new request
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    step(0, 0, 0, 0, 1);
    chk("t2_valid", {31'd0, if_id_valid}, 32'd1);
    chk("t2_rs",    {22'd0, if_id_rs1, if_id_rs2}, {22'd0, 5'd1, 5'd2});
    chk("t2_next",  imem_addr, 32'h8);
    chk("t2_req",   {31'd0, imem_req}, 32'd1);

    // redirect while waiting on a 3-cycle response
    step(0, 0, 0, 1, 3);
    step(0, 1, 32'h100, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("t3_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t3_req",   {31'd0, imem_req}, 32'd1);
    chk("t3_addr",  imem_addr, 32'h100);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // redirect beats stall, target low bits dropped
    step(1, 1, 32'h203, 0, 1);
    chk("t4_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t4_instr", if_id_instr, NOP);
    chk("t4_addr",  imem_addr, 32'h200);

    // pc wrap
    step(0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_req",  {31'd0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom,
           $urandom % 2 == 1, int'($urandom_range(1, 3)));
    chk("deliv_progress", {31'd0, n_deliv > 100}, 32'd1);

    // reset while WAIT; stale response must be ignored
    for (int i = 0; i < 20 && !imem_req; i++) step(0, 0, 0, 0, 1);
    chk("t6_in_req", {31'd0, imem_req}, 32'd1);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 1);
    rst_n = 0; #1;
    chk_reset_vals();
    step(0, 0, 0, 0, 1);
    rst_n = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t6_req",   {31'd0, imem_req}, 32'd1);
    chk("t6_addr",  imem_addr, RPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
